datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk input 1: single system clock; all state updates on rising edge.
REQ-002 clr input 1: asynchronous, active-low reset.
REQ-003 read, write input 1 each: memory read into MDR; memory write from MDR.
REQ-004 PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout input 1 each: bus-drive strobes, in port order after write.
REQ-005 MARIn, PCIn, MDRIn, IRIn, YIn input 1 each: register load enables, in port order after HIout.
REQ-006 IncPC input 1: ALU computes bus+1; Z loads.
REQ-007 HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn input 1 each: load enables. CIn is accepted and ignored.
REQ-008 Gra, Grb, Grc input 1 each: select IR field ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
REQ-009 RIn, Rout, BAout input 1 each: write, read and base-address-read of the selected general register.
REQ-010 add, subtract, multiply, divide input 1 each: ALU operation selects.
REQ-011 Port order is exactly REQ-001..REQ-010 as listed, 35 ports total, no outputs; observation is hierarchical.

Function
REQ-012 32-bit bus; driver encoder priority: PCout > Zlowout > Zhighout > MDRout > Cout > IN_Portout > LOout > HIout > Rout/BAout; no strobe drives 0.
REQ-013 Register file R0..R15, 32-bit. Select = OR of (Gra&ra, Grb&rb, Grc&rc); priority Gra > Grb > Grc.
REQ-014 Rout drives the selected register. BAout drives it too, except R0 reads 0.
REQ-015 RIn writes the bus into the selected register at the edge; R0 is writable.
REQ-016 Cout drives sign-extended IR[18:0].
REQ-017 PC, IR, MAR, Y, HI, LO, InPort and OutPort are 32-bit and load from the bus when their enable is high; MAR uses bits [8:0] as the memory address.
REQ-018 MDR loads when MDRIn: from mem[MAR] if read=1, else from the bus.
REQ-019 write=1 stores MDR into mem[MAR] at the edge; memory is 512x32, zero-initialised at time 0 and not cleared by reset.
REQ-020 Z is 64-bit (Zhigh:Zlow) and loads when ZIn or IncPC is high.
REQ-021 ALU op priority: IncPC > add > subtract > multiply > divide; none selected gives Z={0,bus}.
REQ-022 IncPC: Z={0,bus+1}.
REQ-023 add: Z={0,Y+bus}, mod 2^32.
REQ-024 subtract: Z={0,Y-bus}, mod 2^32.
REQ-025 multiply: Z = signed 64-bit Y*bus.
REQ-026 divide: Zlow = signed Y/bus truncated toward zero, Zhigh = remainder (sign of Y); if bus=0 then Zlow=0xFFFFFFFF, Zhigh=Y.
REQ-027 CONIn latches CON from C2=IR[20:19] evaluated on the bus: 00 zero, 01 nonzero, 10 bus[31]=0, 11 bus[31]=1.
REQ-028 Simultaneous loads of different registers in one cycle are all honoured from the same bus value.

Reset
REQ-029 clr=0 immediately clears PC, IR, MAR, MDR, Y, Z, HI, LO, CON, InPort, OutPort and R0..R15 to 0, regardless of clk.
REQ-030 While clr=0 no register loads and memory writes are blocked; normal operation resumes on the first rising edge after clr returns high.

Structure
REQ-031 A shared package holds the widths (32, 64), the memory depth (512), the C2 encodings and the bus-select encoding.
REQ-032 Natural sub-modules are alu (combinational, REQ-021..026) and reg32 (enable, async clear), instantiated repeatedly.

Verification
REQ-033 Fetch: mem[0]=0x1A1C0005, PC=0; cycle 1 PCout,MARIn,IncPC; cycle 2 Zlowout,PCIn,read,MDRIn; cycle 3 MDRout,IRIn -> PC=1, IR=0x1A1C0005.
REQ-034 Immediate add: IR rb=R3=10, Cout sign-extends -3; sequence Grb,Rout,YIn; then add,Cout,ZIn; then Zlowout,Gra,RIn -> ra register = 7.
REQ-035 multiply: Y=0xFFFFFFFE (-2), bus=3 -> Z=0xFFFFFFFF_FFFFFFFA; then HiIn/LoIn via Zhighout/Zlowout capture the two halves.
REQ-036 divide: Y=-7, bus=2 -> Zlow=0xFFFFFFFD, Zhigh=0xFFFFFFFF; bus=0 -> Zlow=0xFFFFFFFF, Zhigh=Y.
REQ-037 BAout with rb=0 and R0=0x55 -> bus 0; Rout with the same select -> bus 0x55.
REQ-038 Reset mid-operation: load PC=0x10 and R5=9, pulse clr low between edges -> both read 0 immediately, and mem contents are unchanged.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared widths, memory geometry and encodings for the single-bus datapath.
package datapath_pkg;
   localparam int DATA_W    = 32;
   localparam int WIDE_W    = 64;
   localparam int MEM_DEPTH = 512;
   localparam int ADDR_W    = $clog2(MEM_DEPTH);
   localparam int REG_COUNT = 16;

   // C2 field of IR[20:19], evaluated against the bus value by CONIn.
   typedef enum logic [1:0] {
      C2_ZERO    = 2'b00,
      C2_NONZERO = 2'b01,
      C2_NONNEG  = 2'b10,
      C2_NEG     = 2'b11
   } c2Cond_e;

   typedef enum logic [3:0] {
      BUS_NONE,
      BUS_PC,
      BUS_ZLOW,
      BUS_ZHIGH,
      BUS_MDR,
      BUS_C,
      BUS_INPORT,
      BUS_LO,
      BUS_HI,
      BUS_REG,
      BUS_BA
   } busSel_e;

   function automatic logic [DATA_W-1:0] signExtendC(input logic [18:0] field);
      return {{(DATA_W-19){field[18]}}, field};
   endfunction
endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU producing the 64-bit Z value from Y and the bus.
module alu
   import datapath_pkg::*;
(
   input  logic [DATA_W-1:0] y_i,
   input  logic [DATA_W-1:0] bus_i,
   input  logic              incPc_i,
   input  logic              add_i,
   input  logic              sub_i,
   input  logic              mul_i,
   input  logic              div_i,
   output logic [WIDE_W-1:0] z_o
);
   logic signed [WIDE_W-1:0] product;
   logic signed [DATA_W-1:0] quotient;
   logic signed [DATA_W-1:0] remainder;

   always_comb begin
      product   = $signed({{DATA_W{y_i[DATA_W-1]}}, y_i}) *
                  $signed({{DATA_W{bus_i[DATA_W-1]}}, bus_i});
      // Divide by zero yields all-ones quotient and passes Y through as remainder.
      quotient  = '1;
      remainder = y_i;
      if (bus_i != '0) begin
         quotient  = $signed(y_i) / $signed(bus_i);
         remainder = $signed(y_i) % $signed(bus_i);
      end

      z_o = {{DATA_W{1'b0}}, bus_i};
      if (incPc_i)
         z_o = {{DATA_W{1'b0}}, bus_i + DATA_W'(1)};
      else if (add_i)
         z_o = {{DATA_W{1'b0}}, y_i + bus_i};
      else if (sub_i)
         z_o = {{DATA_W{1'b0}}, y_i - bus_i};
      else if (mul_i)
         z_o = product;
      else if (div_i)
         z_o = {remainder, quotient};
   end
endmodule

// File: rtl/datapath_reg32.sv
// Loadable register with asynchronous active-low clear.
module reg32
   import datapath_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q_o <= '0;
      else if (en_i)
         q_o <= d_i;
   end
endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, special registers, ALU, 512x32 memory.
module datapath
   import datapath_pkg::*;
(
   input logic clk,
   input logic clr,
   input logic read,
   input logic write,
   input logic PCout,
   input logic Zlowout,
   input logic Zhighout,
   input logic MDRout,
   input logic Cout,
   input logic IN_Portout,
   input logic LOout,
   input logic HIout,
   input logic MARIn,
   input logic PCIn,
   input logic MDRIn,
   input logic IRIn,
   input logic YIn,
   input logic IncPC,
   input logic HiIn,
   input logic LoIn,
   input logic CIn,
   input logic InIn,
   input logic OutIn,
   input logic ZIn,
   input logic CONIn,
   input logic Gra,
   input logic Grb,
   input logic Grc,
   input logic RIn,
   input logic Rout,
   input logic BAout,
   input logic add,
   input logic subtract,
   input logic multiply,
   input logic divide
);
   busSel_e           busSel;
   logic [DATA_W-1:0] busDrive;
   logic [DATA_W-1:0] bus;
   logic [DATA_W-1:0] pc_q, ir_q, mar_q, mdr_q, mdr_d, y_q, hi_q, lo_q;
   logic [DATA_W-1:0] inPort_q, outPort_q, zLow_q, zHigh_q;
   logic [WIDE_W-1:0] aluZ;
   logic              con_q, con_d;
   logic [3:0]        regSel;
   logic [DATA_W-1:0] regs_q [REG_COUNT];
   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic              unused;

   assign unused = ^{CIn, outPort_q, ir_q[31:27], mar_q[DATA_W-1:ADDR_W]};

   always_comb begin
      busSel = BUS_NONE;
      if (PCout)           busSel = BUS_PC;
      else if (Zlowout)    busSel = BUS_ZLOW;
      else if (Zhighout)   busSel = BUS_ZHIGH;
      else if (MDRout)     busSel = BUS_MDR;
      else if (Cout)       busSel = BUS_C;
      else if (IN_Portout) busSel = BUS_INPORT;
      else if (LOout)      busSel = BUS_LO;
      else if (HIout)      busSel = BUS_HI;
      else if (Rout)       busSel = BUS_REG;
      else if (BAout)      busSel = BUS_BA;
   end

   always_comb begin
      regSel = '0;
      if (Gra)      regSel = ir_q[26:23];
      else if (Grb) regSel = ir_q[22:19];
      else if (Grc) regSel = ir_q[18:15];
   end

   // BAout treats R0 as a hard zero so it can serve as "no base register".
   always_comb begin
      busDrive = '0;
      case (busSel)
         BUS_PC:     busDrive = pc_q;
         BUS_ZLOW:   busDrive = zLow_q;
         BUS_ZHIGH:  busDrive = zHigh_q;
         BUS_MDR:    busDrive = mdr_q;
         BUS_C:      busDrive = signExtendC(ir_q[18:0]);
         BUS_INPORT: busDrive = inPort_q;
         BUS_LO:     busDrive = lo_q;
         BUS_HI:     busDrive = hi_q;
         BUS_REG:    busDrive = regs_q[regSel];
         BUS_BA:     busDrive = (regSel == 4'd0) ? '0 : regs_q[regSel];
         default:    busDrive = '0;
      endcase
   end

   assign bus = busDrive;

   assign mdr_d = read ? mem_q[mar_q[ADDR_W-1:0]] : bus;

   reg32 uPc      (.clk(clk), .rst_n(clr), .en_i(PCIn),  .d_i(bus),   .q_o(pc_q));
   reg32 uIr      (.clk(clk), .rst_n(clr), .en_i(IRIn),  .d_i(bus),   .q_o(ir_q));
   reg32 uMar     (.clk(clk), .rst_n(clr), .en_i(MARIn), .d_i(bus),   .q_o(mar_q));
   reg32 uMdr     (.clk(clk), .rst_n(clr), .en_i(MDRIn), .d_i(mdr_d), .q_o(mdr_q));
   reg32 uY       (.clk(clk), .rst_n(clr), .en_i(YIn),   .d_i(bus),   .q_o(y_q));
   reg32 uHi      (.clk(clk), .rst_n(clr), .en_i(HiIn),  .d_i(bus),   .q_o(hi_q));
   reg32 uLo      (.clk(clk), .rst_n(clr), .en_i(LoIn),  .d_i(bus),   .q_o(lo_q));
   reg32 uInPort  (.clk(clk), .rst_n(clr), .en_i(InIn),  .d_i(bus),   .q_o(inPort_q));
   reg32 uOutPort (.clk(clk), .rst_n(clr), .en_i(OutIn), .d_i(bus),   .q_o(outPort_q));
   reg32 uZLow    (.clk(clk), .rst_n(clr), .en_i(ZIn | IncPC), .d_i(aluZ[DATA_W-1:0]),      .q_o(zLow_q));
   reg32 uZHigh   (.clk(clk), .rst_n(clr), .en_i(ZIn | IncPC), .d_i(aluZ[WIDE_W-1:DATA_W]), .q_o(zHigh_q));

   for (genvar i = 0; i < REG_COUNT; i++) begin : genRegs
      reg32 uReg (
         .clk   (clk),
         .rst_n (clr),
         .en_i  (RIn && (regSel == 4'(i))),
         .d_i   (bus),
         .q_o   (regs_q[i])
      );
   end

   alu uAlu (
      .y_i     (y_q),
      .bus_i   (bus),
      .incPc_i (IncPC),
      .add_i   (add),
      .sub_i   (subtract),
      .mul_i   (multiply),
      .div_i   (divide),
      .z_o     (aluZ)
   );

   always_comb begin
      case (c2Cond_e'(ir_q[20:19]))
         C2_ZERO:    con_d = (bus == '0);
         C2_NONZERO: con_d = (bus != '0);
         C2_NONNEG:  con_d = ~bus[DATA_W-1];
         default:    con_d = bus[DATA_W-1];
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         con_q <= 1'b0;
      else if (CONIn)
         con_q <= con_d;
   end

   // Memory is deliberately outside the reset domain; clr only gates writes.
   always_ff @(posedge clk) begin
      if (clr && write)
         mem_q[mar_q[ADDR_W-1:0]] <= mdr_q;
   end
endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath; constants are injected by forcing the bus.
module tb_datapath;
   logic clk = 1'b0;
   logic clr = 1'b1;
   logic read, write;
   logic PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout;
   logic MARIn, PCIn, MDRIn, IRIn, YIn, IncPC;
   logic HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn;
   logic Gra, Grb, Grc, RIn, Rout, BAout;
   logic add, subtract, multiply, divide;

   logic [31:0] busForce;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   datapath dut (
      .clk(clk), .clr(clr), .read(read), .write(write),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
      .Cout(Cout), .IN_Portout(IN_Portout), .LOout(LOout), .HIout(HIout),
      .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn),
      .IncPC(IncPC), .HiIn(HiIn), .LoIn(LoIn), .CIn(CIn), .InIn(InIn),
      .OutIn(OutIn), .ZIn(ZIn), .CONIn(CONIn), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .RIn(RIn), .Rout(Rout), .BAout(BAout), .add(add), .subtract(subtract),
      .multiply(multiply), .divide(divide)
   );

   task automatic clearControls();
      {read, write, PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout} = '0;
      {MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn} = '0;
      {Gra, Grb, Grc, RIn, Rout, BAout, add, subtract, multiply, divide} = '0;
   endtask

   task automatic driveBus(input logic [31:0] value);
      busForce = value;
      force dut.bus = busForce;
   endtask

   // One clock step: controls set beforehand take effect at this edge, then everything idles.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      release dut.bus;
      clearControls();
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      clearControls();
      busForce = '0;
      #2 clr = 1'b0;
      #1;
      checkOutput("reset_pc", 64'(dut.pc_q), 64'h0);
      checkOutput("reset_z", {dut.zHigh_q, dut.zLow_q}, 64'h0);
      checkOutput("reset_con", 64'(dut.con_q), 64'h0);
      #9 clr = 1'b1;

      $display("[TB] preload mem[0] through MDR");
      driveBus(32'h1A1C0005); MDRIn = 1; applyStimulus();
      checkOutput("mdr_from_bus", 64'(dut.mdr_q), 64'h1A1C0005);
      write = 1; applyStimulus();
      checkOutput("mem0_write", 64'(dut.mem_q[0]), 64'h1A1C0005);

      $display("[TB] instruction fetch");
      PCout = 1; MARIn = 1; IncPC = 1; applyStimulus();
      checkOutput("fetch1_mar", 64'(dut.mar_q), 64'h0);
      checkOutput("fetch1_z", {dut.zHigh_q, dut.zLow_q}, 64'h1);
      Zlowout = 1; PCIn = 1; read = 1; MDRIn = 1; applyStimulus();
      checkOutput("fetch2_pc", 64'(dut.pc_q), 64'h1);
      checkOutput("fetch2_mdr", 64'(dut.mdr_q), 64'h1A1C0005);
      MDRout = 1; IRIn = 1; applyStimulus();
      checkOutput("fetch3_ir", 64'(dut.ir_q), 64'h1A1C0005);

      Cout = 1; #1;
      checkOutput("cout_sext", 64'(dut.bus), 64'hFFFC0005);
      Cout = 0; PCout = 1; MDRout = 1; #1;
      checkOutput("bus_priority", 64'(dut.bus), 64'h1);
      clearControls();

      $display("[TB] immediate add");
      driveBus(32'h029FFFFD); IRIn = 1; applyStimulus();
      driveBus(32'd10); Grb = 1; RIn = 1; applyStimulus();
      checkOutput("r3_load", 64'(dut.regs_q[3]), 64'd10);
      Grb = 1; Rout = 1; YIn = 1; applyStimulus();
      checkOutput("y_load", 64'(dut.y_q), 64'd10);
      add = 1; Cout = 1; ZIn = 1; applyStimulus();
      checkOutput("addi_z", {dut.zHigh_q, dut.zLow_q}, 64'd7);
      Zlowout = 1; Gra = 1; RIn = 1; applyStimulus();
      checkOutput("addi_r5", 64'(dut.regs_q[5]), 64'd7);

      driveBus(32'h80000000); CONIn = 1; applyStimulus();
      checkOutput("con_neg_true", 64'(dut.con_q), 64'h1);
      driveBus(32'd5); CONIn = 1; applyStimulus();
      checkOutput("con_neg_false", 64'(dut.con_q), 64'h0);

      driveBus(32'd3); subtract = 1; ZIn = 1; applyStimulus();
      checkOutput("sub_z", {dut.zHigh_q, dut.zLow_q}, 64'd7);
      driveBus(32'd12); subtract = 1; ZIn = 1; applyStimulus();
      checkOutput("sub_wrap", {dut.zHigh_q, dut.zLow_q}, 64'h00000000_FFFFFFFE);

      $display("[TB] multiply and HI/LO capture");
      driveBus(32'hFFFFFFFE); YIn = 1; applyStimulus();
      driveBus(32'd3); multiply = 1; ZIn = 1; applyStimulus();
      checkOutput("mul_z", {dut.zHigh_q, dut.zLow_q}, 64'hFFFFFFFF_FFFFFFFA);
      Zhighout = 1; HiIn = 1; applyStimulus();
      checkOutput("hi_capture", 64'(dut.hi_q), 64'hFFFFFFFF);
      Zlowout = 1; LoIn = 1; applyStimulus();
      checkOutput("lo_capture", 64'(dut.lo_q), 64'hFFFFFFFA);
      LOout = 1; #1;
      checkOutput("lo_out_bus", 64'(dut.bus), 64'hFFFFFFFA);
      clearControls();

      $display("[TB] divide");
      driveBus(32'hFFFFFFF9); YIn = 1; applyStimulus();
      driveBus(32'd2); divide = 1; ZIn = 1; applyStimulus();
      checkOutput("div_z", {dut.zHigh_q, dut.zLow_q}, 64'hFFFFFFFF_FFFFFFFD);
      driveBus(32'd0); divide = 1; ZIn = 1; applyStimulus();
      checkOutput("div_by_zero", {dut.zHigh_q, dut.zLow_q}, 64'hFFFFFFF9_FFFFFFFF);
      driveBus(32'd2); add = 1; multiply = 1; ZIn = 1; applyStimulus();
      checkOutput("op_priority", {dut.zHigh_q, dut.zLow_q}, 64'h00000000_FFFFFFFB);
      driveBus(32'h1234); ZIn = 1; applyStimulus();
      checkOutput("no_op_pass", {dut.zHigh_q, dut.zLow_q}, 64'h00000000_00001234);

      $display("[TB] BAout versus Rout on R0");
      driveBus(32'h0); IRIn = 1; applyStimulus();
      driveBus(32'h55); Grb = 1; RIn = 1; applyStimulus();
      checkOutput("r0_write", 64'(dut.regs_q[0]), 64'h55);
      Grb = 1; BAout = 1; #1;
      checkOutput("baout_r0", 64'(dut.bus), 64'h0);
      BAout = 0; Rout = 1; #1;
      checkOutput("rout_r0", 64'(dut.bus), 64'h55);
      clearControls();
      driveBus(32'h0); CONIn = 1; applyStimulus();
      checkOutput("con_zero_true", 64'(dut.con_q), 64'h1);

      driveBus(32'h203); MARIn = 1; applyStimulus();
      driveBus(32'hABCD); MDRIn = 1; applyStimulus();
      write = 1; applyStimulus();
      checkOutput("mar_addr_wrap", 64'(dut.mem_q[3]), 64'hABCD);

      $display("[TB] asynchronous reset mid-operation");
      driveBus(32'h10); PCIn = 1; applyStimulus();
      driveBus(32'h029FFFFD); IRIn = 1; applyStimulus();
      driveBus(32'd9); Gra = 1; RIn = 1; applyStimulus();
      checkOutput("pre_reset_pc", 64'(dut.pc_q), 64'h10);
      checkOutput("pre_reset_r5", 64'(dut.regs_q[5]), 64'd9);
      clr = 1'b0; #1;
      checkOutput("async_pc", 64'(dut.pc_q), 64'h0);
      checkOutput("async_r5", 64'(dut.regs_q[5]), 64'h0);
      checkOutput("async_ir", 64'(dut.ir_q), 64'h0);
      driveBus(32'h77); PCIn = 1; write = 1; applyStimulus();
      checkOutput("held_pc", 64'(dut.pc_q), 64'h0);
      checkOutput("mem0_kept", 64'(dut.mem_q[0]), 64'h1A1C0005);
      checkOutput("mem3_kept", 64'(dut.mem_q[3]), 64'hABCD);
      clr = 1'b1;
      driveBus(32'h22); PCIn = 1; applyStimulus();
      checkOutput("resume_pc", 64'(dut.pc_q), 64'h22);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
